lock_cfg_writer: RTL and testbench

- Initiator side for a bank of lockable configuration registers: accepts write requests over a valid/ready port and drives per-register write strobes and shared write data.
- Reads each write back to confirm it landed, then issues the lock pulse after the request marked last.
- After locking, it rejects further requests with an error instead of dropping them silently.
- Never drives any debug or trusted override path; sits between the boot or config master and the locked register bank.

---
 rtl/lock_cfg_pkg.sv | 24 ++
 rtl/lock_cfg_writer_if.sv | 33 +++
 rtl/lock_cfg_rdmux.sv | 20 ++
 rtl/lock_cfg_writer.sv | 182 ++++++++++++++++++
 tb/tb_lock_cfg_writer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/lock_cfg_pkg.sv
// Shared constants for the lockable configuration writer: response codes and FSM encoding.
// PROBE/PCHK states exist only when LOCK_CFG_PROBE_EN is defined.
package lock_cfg_pkg;

  localparam logic [1:0] RESP_OK       = 2'd0;
  localparam logic [1:0] RESP_BAD_ADDR = 2'd1;
  localparam logic [1:0] RESP_MISMATCH = 2'd2;
  localparam logic [1:0] RESP_LOCKED   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_CHK,
    ST_LOCK,
    ST_LOCKED,
    ST_ERR
`ifdef LOCK_CFG_PROBE_EN
    ,
    ST_PROBE,
    ST_PCHK
`endif
  } state_t;

endpackage

// File: rtl/lock_cfg_writer_if.sv
// Request/response port plus register-bank port of the lock_cfg_writer.
// slave = the writer itself; master = config master together with the register bank.
interface lock_cfg_writer_if #(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 2
);
  logic                       req_valid;
  logic                       req_ready;
  logic [ADDR_W-1:0]          req_addr;
  logic [DATA_W-1:0]          req_data;
  logic                       req_last;
  logic                       resp_valid;
  logic [1:0]                 resp_err;
  logic [NUM_REGS-1:0]        reg_write;
  logic [DATA_W-1:0]          reg_data;
  logic                       reg_lock;
  logic [NUM_REGS*DATA_W-1:0] reg_rdata;
  logic                       lock_done;
  logic                       err_flag;

  modport slave (
    input  req_valid, req_addr, req_data, req_last, reg_rdata,
    output req_ready, resp_valid, resp_err, reg_write, reg_data, reg_lock,
           lock_done, err_flag
  );

  modport master (
    output req_valid, req_addr, req_data, req_last, reg_rdata,
    input  req_ready, resp_valid, resp_err, reg_write, reg_data, reg_lock,
           lock_done, err_flag
  );
endinterface

// File: rtl/lock_cfg_rdmux.sv
// Combinational pick of one DATA_W register slice out of the flattened bank read bus.
module lock_cfg_rdmux #(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 2
) (
  input  logic [NUM_REGS*DATA_W-1:0] rdata,
  input  logic [ADDR_W-1:0]          sel,
  output logic [DATA_W-1:0]          slice
);

  // Explicit compare loop keeps out-of-range selects at zero instead of X.
  always_comb begin
    slice = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel == ADDR_W'(i)) slice = rdata[i*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/lock_cfg_writer.sv
// Initiator for a bank of lockable config registers: write, read-back check, lock, then reject.
// Optional LOCK_CFG_PROBE_EN adds a post-lock probe write to reg 0 that must be ignored by the bank.
module lock_cfg_writer
  import lock_cfg_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 2
) (
  input logic              Clk,
  input logic              reset,
  lock_cfg_writer_if.slave bus
);

  localparam logic [NUM_REGS-1:0] ONE_HOT0 = {{(NUM_REGS-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                last_q, last_d;
  logic                ready_q, ready_d;
  logic                rvld_q, rvld_d;
  logic [1:0]          rerr_q, rerr_d;
  logic [NUM_REGS-1:0] wr_q, wr_d;
  logic [DATA_W-1:0]   wdat_q, wdat_d;
  logic                lock_q, lock_d;
  logic                done_q, done_d;
  logic                eflag_q, eflag_d;
  logic [ADDR_W-1:0]   rd_sel;
  logic [DATA_W-1:0]   rd_slice;
`ifdef LOCK_CFG_PROBE_EN
  logic [DATA_W-1:0]   probe_q, probe_d;
`endif

  // Read-back of the target in CHK; register 0 otherwise (probe path).
  assign rd_sel = (state_q == ST_CHK) ? addr_q : '0;

  lock_cfg_rdmux #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rdmux (
    .rdata (bus.reg_rdata),
    .sel   (rd_sel),
    .slice (rd_slice)
  );

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      ready_q <= 1'b0;
      rvld_q  <= 1'b0;
      rerr_q  <= RESP_OK;
      wr_q    <= '0;
      wdat_q  <= '0;
      lock_q  <= 1'b0;
      done_q  <= 1'b0;
      eflag_q <= 1'b0;
`ifdef LOCK_CFG_PROBE_EN
      probe_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      ready_q <= ready_d;
      rvld_q  <= rvld_d;
      rerr_q  <= rerr_d;
      wr_q    <= wr_d;
      wdat_q  <= wdat_d;
      lock_q  <= lock_d;
      done_q  <= done_d;
      eflag_q <= eflag_d;
`ifdef LOCK_CFG_PROBE_EN
      probe_q <= probe_d;
`endif
    end
  end

  // Outputs are registered: each branch computes what the next state's cycle drives.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
    ready_d = 1'b0;
    rvld_d  = 1'b0;
    rerr_d  = RESP_OK;
    wr_d    = '0;
    wdat_d  = wdat_q;
    lock_d  = 1'b0;
    done_d  = 1'b0;
    eflag_d = 1'b0;
`ifdef LOCK_CFG_PROBE_EN
    probe_d = probe_q;
`endif
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (bus.req_valid && ready_q) begin
          if (int'(bus.req_addr) >= NUM_REGS) begin
            rvld_d = 1'b1;
            rerr_d = RESP_BAD_ADDR;
          end else begin
            addr_d  = bus.req_addr;
            data_d  = bus.req_data;
            last_d  = bus.req_last;
            wr_d    = ONE_HOT0 << bus.req_addr;
            wdat_d  = bus.req_data;
            ready_d = 1'b0;
            state_d = ST_WR;
          end
        end
      end
      ST_WR: state_d = ST_CHK;
      ST_CHK: begin
        if (rd_slice != data_q) begin
          rvld_d  = 1'b1;
          rerr_d  = RESP_MISMATCH;
          eflag_d = 1'b1;
          state_d = ST_ERR;
        end else if (last_q) begin
          lock_d  = 1'b1;
          state_d = ST_LOCK;
        end else begin
          rvld_d  = 1'b1;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_LOCK: begin
`ifdef LOCK_CFG_PROBE_EN
        // Nothing writes during LOCK, so reg 0 read here equals its value in PROBE.
        wr_d    = ONE_HOT0;
        wdat_d  = ~rd_slice;
        probe_d = rd_slice;
        state_d = ST_PROBE;
`else
        rvld_d  = 1'b1;
        done_d  = 1'b1;
        ready_d = 1'b1;
        state_d = ST_LOCKED;
`endif
      end
`ifdef LOCK_CFG_PROBE_EN
      ST_PROBE: state_d = ST_PCHK;
      ST_PCHK: begin
        rvld_d = 1'b1;
        if (rd_slice == probe_q) begin
          done_d  = 1'b1;
          ready_d = 1'b1;
          state_d = ST_LOCKED;
        end else begin
          rerr_d  = RESP_MISMATCH;
          eflag_d = 1'b1;
          state_d = ST_ERR;
        end
      end
`endif
      ST_LOCKED: begin
        done_d  = 1'b1;
        ready_d = 1'b1;
        if (bus.req_valid && ready_q) begin
          rvld_d = 1'b1;
          rerr_d = RESP_LOCKED;
        end
      end
      ST_ERR:  eflag_d = 1'b1;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = rvld_q;
  assign bus.resp_err   = rerr_q;
  assign bus.reg_write  = wr_q;
  assign bus.reg_data   = wdat_q;
  assign bus.reg_lock   = lock_q;
  assign bus.lock_done  = done_q;
  assign bus.err_flag   = eflag_q;

endmodule

// File: tb/tb_lock_cfg_writer.sv
// Directed bench for lock_cfg_writer: a 4-register bank (with lock and stuck-reg model) and a 3-register bank.
module tb_lock_cfg_writer;
  import lock_cfg_pkg::*;

  logic Clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 Clk = ~Clk;

  lock_cfg_writer_if #(.NUM_REGS(4), .DATA_W(16), .ADDR_W(2)) bus_a ();
  lock_cfg_writer_if #(.NUM_REGS(3), .DATA_W(16), .ADDR_W(2)) bus_b ();

  lock_cfg_writer #(.NUM_REGS(4), .DATA_W(16), .ADDR_W(2)) dut_a (
    .Clk(Clk), .reset(reset), .bus(bus_a.slave));
  lock_cfg_writer #(.NUM_REGS(3), .DATA_W(16), .ADDR_W(2)) dut_b (
    .Clk(Clk), .reset(reset), .bus(bus_b.slave));

  // Bank models: writes ignored once locked (unless ign_lock); reg 3 of bank A can be stuck at 0.
  logic [15:0] bank_a [4];
  logic [15:0] bank_b [3];
  logic        lk_a, lk_b, stuck3, ign_lock;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) bank_a[i] <= '0;
      lk_a <= 1'b0;
    end else begin
      if (bus_a.reg_lock) lk_a <= 1'b1;
      for (int i = 0; i < 4; i++)
        if (bus_a.reg_write[i] && !(lk_a && !ign_lock) && !(stuck3 && i == 3))
          bank_a[i] <= bus_a.reg_data;
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) bank_b[i] <= '0;
      lk_b <= 1'b0;
    end else begin
      if (bus_b.reg_lock) lk_b <= 1'b1;
      for (int i = 0; i < 3; i++)
        if (bus_b.reg_write[i] && !lk_b) bank_b[i] <= bus_b.reg_data;
    end
  end

  assign bus_a.reg_rdata = {bank_a[3], bank_a[2], bank_a[1], bank_a[0]};
  assign bus_b.reg_rdata = {bank_b[2], bank_b[1], bank_b[0]};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs_a();
    return 64'({bus_a.req_ready, bus_a.resp_valid, bus_a.resp_err, bus_a.reg_write,
                bus_a.reg_data, bus_a.reg_lock, bus_a.lock_done, bus_a.err_flag});
  endfunction

  function automatic logic [63:0] outs_b();
    return 64'({bus_b.req_ready, bus_b.resp_valid, bus_b.resp_err, bus_b.reg_write,
                bus_b.reg_data, bus_b.reg_lock, bus_b.lock_done, bus_b.err_flag});
  endfunction

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic req_a(input logic [1:0] a, input logic [15:0] d, input logic l);
    int n = 0;
    while (bus_a.req_ready !== 1'b1 && n < 20) begin @(negedge Clk); n++; end
    if (n >= 20) chk("req_a_ready_timeout", 64'(bus_a.req_ready), 64'd1);
    bus_a.req_valid = 1'b1; bus_a.req_addr = a; bus_a.req_data = d; bus_a.req_last = l;
    @(negedge Clk);
    bus_a.req_valid = 1'b0;
  endtask

  task automatic req_b(input logic [1:0] a, input logic [15:0] d, input logic l);
    int n = 0;
    while (bus_b.req_ready !== 1'b1 && n < 20) begin @(negedge Clk); n++; end
    if (n >= 20) chk("req_b_ready_timeout", 64'(bus_b.req_ready), 64'd1);
    bus_b.req_valid = 1'b1; bus_b.req_addr = a; bus_b.req_data = d; bus_b.req_last = l;
    @(negedge Clk);
    bus_b.req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    bus_a.req_valid = 0; bus_a.req_addr = 0; bus_a.req_data = 0; bus_a.req_last = 0;
    bus_b.req_valid = 0; bus_b.req_addr = 0; bus_b.req_data = 0; bus_b.req_last = 0;
    stuck3 = 0; ign_lock = 0;
    repeat (2) @(negedge Clk);
    chk("rst_outs_a", outs_a(), 64'd0);
    chk("rst_outs_b", outs_b(), 64'd0);
    reset = 1'b0;
    @(negedge Clk);
    chk("idle_ready", 64'(bus_a.req_ready), 64'd1);

    // Plain write to reg 1
    req_a(2'd1, 16'hA5A5, 1'b0);
    chk("t1_wr", 64'(bus_a.reg_write), 64'b0010);
    chk("t1_wdata", 64'(bus_a.reg_data), 64'hA5A5);
    chk("t1_rdy_low", 64'(bus_a.req_ready), 64'd0);
    @(negedge Clk);
    chk("t1_wr_pulse", 64'(bus_a.reg_write), 64'd0);
    chk("t1_no_early_resp", 64'(bus_a.resp_valid), 64'd0);
    @(negedge Clk);
    chk("t1_resp", 64'({bus_a.resp_valid, bus_a.resp_err}), 64'b100);
    chk("t1_ready", 64'(bus_a.req_ready), 64'd1);
    chk("t1_bank", 64'(bank_a[1]), 64'hA5A5);
    @(negedge Clk);
    chk("t1_resp_pulse", 64'(bus_a.resp_valid), 64'd0);

    // Last write to reg 2, then lock
    req_a(2'd2, 16'h1234, 1'b1);
    chk("t2_wr", 64'(bus_a.reg_write), 64'b0100);
    @(negedge Clk);
    chk("t2_no_lock_in_chk", 64'(bus_a.reg_lock), 64'd0);
    @(negedge Clk);
    chk("t2_lock", 64'(bus_a.reg_lock), 64'd1);
    chk("t2_no_wr_with_lock", 64'(bus_a.reg_write), 64'd0);
    chk("t2_no_resp_in_lock", 64'(bus_a.resp_valid), 64'd0);
`ifdef LOCK_CFG_PROBE_EN
    @(negedge Clk);
    chk("t2_probe_wr", 64'(bus_a.reg_write), 64'b0001);
    chk("t2_probe_data", 64'(bus_a.reg_data), 64'hFFFF);
    @(negedge Clk);
`endif
    @(negedge Clk);
    chk("t2_resp", 64'({bus_a.resp_valid, bus_a.resp_err}), 64'b100);
    chk("t2_lock_done", 64'(bus_a.lock_done), 64'd1);
    chk("t2_lock_pulse", 64'(bus_a.reg_lock), 64'd0);
    chk("t2_bank", 64'(bank_a[2]), 64'h1234);
    @(negedge Clk);
    chk("t2_resp_pulse", 64'(bus_a.resp_valid), 64'd0);

    // Request after lock is rejected
    req_a(2'd0, 16'hFFFF, 1'b0);
    chk("t3_resp", 64'({bus_a.resp_valid, bus_a.resp_err}), 64'b111);
    chk("t3_no_wr", 64'(bus_a.reg_write), 64'd0);
    @(negedge Clk);
    chk("t3_no_wr_later", 64'(bus_a.reg_write), 64'd0);
    chk("t3_resp_pulse", 64'(bus_a.resp_valid), 64'd0);
    chk("t3_bank_unchanged", 64'(bank_a[0]), 64'd0);
    chk("t3_lock_done", 64'(bus_a.lock_done), 64'd1);

    reset = 1'b1;
    #1 chk("t3_rst_outs", outs_a(), 64'd0);
    @(negedge Clk);
    reset = 1'b0;

    // Stuck reg 3 -> mismatch -> ERR
    stuck3 = 1'b1;
    req_a(2'd3, 16'h00FF, 1'b0);
    chk("t4_wr", 64'(bus_a.reg_write), 64'b1000);
    repeat (2) @(negedge Clk);
    chk("t4_resp", 64'({bus_a.resp_valid, bus_a.resp_err}), 64'b110);
    chk("t4_err_flag", 64'(bus_a.err_flag), 64'd1);
    bus_a.req_valid = 1'b1; bus_a.req_addr = 2'd0; bus_a.req_data = 16'h7777;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      chk("t4_err_ready", 64'(bus_a.req_ready), 64'd0);
      chk("t4_err_no_wr", 64'(bus_a.reg_write), 64'd0);
      chk("t4_err_sticky", 64'(bus_a.err_flag), 64'd1);
    end
    bus_a.req_valid = 1'b0;
    #2 reset = 1'b1;
    #1 chk("t4_rst_outs", outs_a(), 64'd0);
    @(negedge Clk);
    reset = 1'b0;
    stuck3 = 1'b0;

    // Reset asserted while the strobe is out
    req_a(2'd1, 16'hBEEF, 1'b0);
    chk("t5_wr", 64'(bus_a.reg_write), 64'b0010);
    #1 reset = 1'b1;
    #1 chk("t5_rst_outs", outs_a(), 64'd0);
    @(negedge Clk);
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      pulses += int'(bus_a.resp_valid);
    end
    chk("t5_no_resp", 64'(pulses), 64'd0);

    // 3-register bank: out-of-range address, then a good write
    req_b(2'd3, 16'h1111, 1'b0);
    chk("t6_bad_resp", 64'({bus_b.resp_valid, bus_b.resp_err}), 64'b101);
    chk("t6_bad_ready", 64'(bus_b.req_ready), 64'd1);
    chk("t6_bad_no_wr", 64'(bus_b.reg_write), 64'd0);
    @(negedge Clk);
    chk("t6_bad_pulse", 64'(bus_b.resp_valid), 64'd0);
    req_b(2'd0, 16'h5555, 1'b0);
    chk("t6_wr", 64'(bus_b.reg_write), 64'b001);
    repeat (2) @(negedge Clk);
    chk("t6_resp", 64'({bus_b.resp_valid, bus_b.resp_err}), 64'b100);
    chk("t6_bank", 64'(bank_b[0]), 64'h5555);

`ifdef LOCK_CFG_PROBE_EN
    // Bank that ignores lock: the probe write lands and is caught
    reset = 1'b1;
    @(negedge Clk);
    reset = 1'b0;
    ign_lock = 1'b1;
    req_a(2'd1, 16'h0F0F, 1'b1);
    repeat (4) @(negedge Clk);
    chk("t7_probe_resp", 64'({bus_a.resp_valid, bus_a.resp_err}), 64'b110);
    chk("t7_probe_err", 64'(bus_a.err_flag), 64'd1);
    chk("t7_probe_no_done", 64'(bus_a.lock_done), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
